io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width; memory depth is 2**ADDR_W bytes.
REQ-002 Parameter INTR_PERIOD, default 32'd100, clk cycles from counter start to intr assertion; minimum 1.
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port io_cs  input  1  chip select from CPU.
REQ-006 Port io_rd  input  1  read strobe, qualified by io_cs.
REQ-007 Port io_wr  input  1  write strobe, qualified by io_cs.
REQ-008 Port Address  input  32  CPU ALU_Out; only Address[ADDR_W-1:0] decoded.
REQ-009 Port D_IN  input  32  write data (CPU D_OUT).
REQ-010 Port io_out  output  32  read data onto shared CPU read bus.
REQ-011 Port intr  output  1  interrupt request to CPU.
REQ-012 Port inta  input  1  interrupt acknowledge from CPU.

Function
REQ-013 Word access big-endian: byte A holds bits 31:24, A+1 23:16, A+2 15:8, A+3 7:0.
REQ-014 Byte address arithmetic modulo 2**ADDR_W; access at 0xFFE wraps to bytes 0xFFE,0xFFF,0x000,0x001.
REQ-015 No alignment requirement; unaligned addresses accessed byte-wise per REQ-013.
REQ-016 Write: io_cs&io_wr&!io_rd at a rising edge stores D_IN into four bytes; visible to a read next cycle.
REQ-017 Read: io_cs&io_rd&!io_wr drives io_out combinationally with the addressed word, zero wait states.
REQ-018 io_out SHALL be 32'hZZZZZZZZ whenever the read condition of REQ-017 is false.
REQ-019 io_cs&io_rd&io_wr together: write performed, io_out high-Z (write wins, no bus contention).
REQ-020 Interrupt FSM states: IDLE, COUNT, REQ, ACK.
REQ-021 IDLE -> COUNT on first clock after reset release; counter loads 0.
REQ-022 COUNT: counter increments each cycle; at count == INTR_PERIOD-1 -> REQ.
REQ-023 REQ: intr=1; stays until inta sampled 1, then -> ACK.
REQ-024 ACK: intr=0; stays until inta sampled 0, then -> COUNT with counter 0.
REQ-025 intr registered, high only in REQ; inta high in COUNT or IDLE ignored.
REQ-026 IO bus accesses and interrupt FSM independent; any overlap permitted.

Reset
REQ-027 reset low asynchronously forces FSM to IDLE, counter to 0, intr to 0.
REQ-028 io_out high-Z during reset regardless of strobes; writes during reset ignored.
REQ-029 Memory array not cleared by reset; contents undefined after power-up, retained across reset.
REQ-030 Reset asserted in REQ or ACK aborts handshake; new period starts after release.

Configuration
REQ-031 Macro IO_INTR_EN: defined -> FSM and counter compiled in per REQ-020..025.
REQ-032 IO_INTR_EN undefined -> no FSM/counter logic; intr tied 0; inta unused; IO bus unchanged.

Structure
REQ-033 Shared package holds FSM state encoding (2-bit IDLE=0,COUNT=1,REQ=2,ACK=3) and default ADDR_W/INTR_PERIOD constants.
REQ-034 One sub-module, intr_gen (FSM plus counter), instantiated only under IO_INTR_EN; memory stays in io_responder.

Verification
REQ-035 Write 0xDEADBEEF at 0x010, read 0x010 next cycle -> io_out=0xDEADBEEF; byte 0x010=0xDE, 0x013=0xEF.
REQ-036 Write 0x11223344 at 0xFFE, read 0x000 -> io_out[31:16]=0x3344; read 0xFFE -> 0x11223344.
REQ-037 io_cs=0 or io_rd=0, and rd+wr together -> io_out=Z; rd+wr write of 0xA5A5A5A5 readable next cycle.
REQ-038 INTR_PERIOD=5, inta=0 -> intr rises 5+1 cycles after reset release, holds 20 cycles; inta 1 for 2 cycles -> intr falls cycle after first inta; next intr 5 cycles after inta falls.
REQ-039 Reset pulsed while intr=1 -> intr 0 immediately (async); period restarts; memory contents unchanged.
REQ-040 Build without IO_INTR_EN, INTR_PERIOD=5, toggle inta -> intr stays 0 for 100 cycles; REQ-035 passes.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared types and defaults for the io_responder slice.
// Holds the interrupt FSM state encoding and default parameter values.
package io_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2,
    ACK   = 2'd3
  } intr_state_e;

  localparam int          ADDR_W_DEF      = 12;
  localparam logic [31:0] INTR_PERIOD_DEF = 32'd100;
  localparam int          WORD_BYTES      = 4;

endpackage

// File: rtl/io_responder_intr_gen.sv
// Periodic interrupt generator: cycle counter plus REQ/ACK handshake FSM.
// Ports: clk, reset (async, active-low), inta (ack in), intr (registered req out).
module intr_gen
  import io_responder_pkg::*;
#(
  parameter logic [31:0] INTR_PERIOD = INTR_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inta,
  output logic intr
);

  localparam logic [31:0] LAST = INTR_PERIOD - 32'd1;

  intr_state_e state, state_nx;
  logic [31:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      intr  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      // Registered so intr is glitch-free and high exactly while in REQ.
      intr  <= (state_nx == REQ);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        state_nx = COUNT;
        cnt_nx   = '0;
      end
      COUNT: begin
        if (cnt == LAST) state_nx = REQ;
        else             cnt_nx   = cnt + 32'd1;
      end
      REQ: begin
        if (inta) state_nx = ACK;
      end
      ACK: begin
        if (!inta) begin
          state_nx = COUNT;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/io_responder.sv
// Byte-addressed big-endian IO memory on a CPU bus, plus optional periodic
// interrupt (enabled by macro IO_INTR_EN).
// Ports: clk, reset (async active-low), io_cs/io_rd/io_wr strobes,
// Address, D_IN (write data), io_out (tri-state read data), intr, inta.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_DEF,
  parameter logic [31:0] INTR_PERIOD = INTR_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] Address,
  input  logic [31:0] D_IN,
  output logic [31:0] io_out,
  output logic        intr,
  input  logic        inta
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] ba  [WORD_BYTES];
  logic [31:0]       rd_word;
  logic              rd_en;
  logic              wr_en;

  // Byte addresses wrap naturally at the ADDR_W-bit width.
  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      ba[i] = Address[ADDR_W-1:0] + ADDR_W'(i);
    end
  end

  // rd+wr together counts as a write; the bus stays released.
  assign wr_en = reset & io_cs & io_wr;
  assign rd_en = reset & io_cs & io_rd & ~io_wr;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rd_word[31-8*i -: 8] = mem[ba[i]];
    end
  end

  // No reset on the array: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem[ba[i]] <= D_IN[31-8*i -: 8];
      end
    end
  end

  assign io_out = rd_en ? rd_word : 32'hzzzzzzzz;

  logic unused_addr;
  assign unused_addr = ^Address[31:ADDR_W];

`ifdef IO_INTR_EN
  intr_gen #(
    .INTR_PERIOD(INTR_PERIOD)
  ) u_intr_gen (
    .clk  (clk),
    .reset(reset),
    .inta (inta),
    .intr (intr)
  );
`else
  assign intr = 1'b0;
  logic unused_intr;
  assign unused_intr = ^{inta, INTR_PERIOD};
`endif

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: reads queue expected words, a
// negedge monitor pops and compares whenever a read is presented.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        io_cs = 1'b0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] D_IN = '0;
  wire  [31:0] io_out;
  logic        intr;
  logic        inta = 1'b0;

  int tests = 0;
  int failed = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  sb_t q[$];

  io_responder #(
    .ADDR_W     (12),
    .INTR_PERIOD(32'd5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_cs  (io_cs),
    .io_rd  (io_rd),
    .io_wr  (io_wr),
    .Address(Address),
    .D_IN   (D_IN),
    .io_out (io_out),
    .intr   (intr),
    .inta   (inta)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every presented read against the scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (reset === 1'b1 && io_cs === 1'b1 && io_rd === 1'b1 &&
        io_wr === 1'b0) begin
      if (q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_read: got %h expected none", io_out);
      end else begin
        e = q.pop_front();
        check(e.name, io_out & e.mask, e.exp & e.mask);
      end
    end
  end

  task automatic idle();
    io_cs = 1'b0;
    io_rd = 1'b0;
    io_wr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a;
    D_IN = d;
    io_cs = 1'b1;
    io_wr = 1'b1;
    io_rd = 1'b0;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input logic [31:0] mask, input string name);
    sb_t e;
    e.name = name;
    e.exp = exp;
    e.mask = mask;
    q.push_back(e);
    Address = a;
    io_cs = 1'b1;
    io_rd = 1'b1;
    io_wr = 1'b0;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic zchk(input string name, input logic cs, input logic r,
                      input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    Address = a;
    D_IN = d;
    io_cs = cs;
    io_rd = r;
    io_wr = w;
    @(negedge clk);
    check(name, io_out, 32'hzzzzzzzz);
    @(posedge clk);
    #1 idle();
  endtask

  // Called just after a reset release that happens #1 after a posedge.
  task automatic period_chk(input string tag);
    repeat (6) @(negedge clk);
    check({tag, "_pre"}, {31'd0, intr}, 32'd0);
    @(negedge clk);
    check({tag, "_rise"}, {31'd0, intr}, 32'd1);
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    zchk("z_in_reset", 1'b1, 1'b1, 1'b0, 32'h010, 32'h0);
    check("intr_reset", {31'd0, intr}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

`ifdef IO_INTR_EN
    period_chk("p1");
    repeat (20) @(negedge clk);
    check("intr_hold", {31'd0, intr}, 32'd1);
    @(posedge clk);
    #1 inta = 1'b1;
    @(negedge clk);
    check("intr_pre_ack", {31'd0, intr}, 32'd1);
    @(negedge clk);
    check("intr_fall", {31'd0, intr}, 32'd0);
    @(posedge clk);
    #1 inta = 1'b0;
    period_chk("p2");
    @(posedge clk);
    #1 inta = 1'b1;
    @(posedge clk);
    #1 inta = 1'b0;
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      inta = i[0];
      @(negedge clk);
      if (intr !== 1'b0) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    inta = 1'b0;
    check("intr_tied0", {31'd0, seen}, 32'd0);
`endif

    wr(32'h010, 32'hDEADBEEF);
    rd(32'h010, 32'hDEADBEEF, 32'hFFFFFFFF, "rd_010");
    rd(32'h013, 32'hEF000000, 32'hFF000000, "byte_013");
    rd(32'h00D, 32'h000000DE, 32'h000000FF, "byte_010");
    rd(32'h011, 32'hADBEEF00, 32'hFFFFFF00, "unaligned_011");
    rd(32'hABC0_0010, 32'hDEADBEEF, 32'hFFFFFFFF, "hi_addr_ignored");
    wr(32'hFFE, 32'h11223344);
    rd(32'h000, 32'h33440000, 32'hFFFF0000, "wrap_000");
    rd(32'hFFE, 32'h11223344, 32'hFFFFFFFF, "wrap_ffe");
    rd(32'hFFD, 32'h00112233, 32'h00FFFFFF, "wrap_ffd");

    zchk("z_cs0", 1'b0, 1'b1, 1'b0, 32'h010, 32'h0);
    zchk("z_rd0", 1'b1, 1'b0, 1'b0, 32'h010, 32'h0);
    zchk("z_rdwr", 1'b1, 1'b1, 1'b1, 32'h020, 32'hA5A5A5A5);
    rd(32'h020, 32'hA5A5A5A5, 32'hFFFFFFFF, "rdwr_written");
    wr(32'h024, 32'h0102_0304);
    rd(32'h022, 32'hA5A50102, 32'hFFFFFFFF, "straddle_022");

`ifdef IO_INTR_EN
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = intr;
    end
    check("intr_wait", {31'd0, seen}, 32'd1);
    #2 reset = 1'b0;
    #1 check("intr_async_clr", {31'd0, intr}, 32'd0);
`else
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("intr_in_reset", {31'd0, intr}, 32'd0);
`endif
    Address = 32'h010;
    D_IN = 32'h12345678;
    io_cs = 1'b1;
    io_wr = 1'b1;
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1 reset = 1'b1;
`ifdef IO_INTR_EN
    period_chk("p3");
`endif
    rd(32'h010, 32'hDEADBEEF, 32'hFFFFFFFF, "retained_010");

    @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL sb_leftover: got %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
